// File: rtl/adder_arb_pkg.sv
// Shared types, limits and pointer helper for the adder share arbiter.
// Define ADDER_ARB_CARRY_EN to widen rsp_sum by one bit and keep the adder carry out.
package adder_arb_pkg;

  localparam int ARB_NREQ_MAX = 8;

`ifdef ADDER_ARB_CARRY_EN
  localparam int ARB_CARRY = 1;
`else
  localparam int ARB_CARRY = 0;
`endif

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/adder_arb_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping at NREQ-1.
// Latency: purely combinational.
// Backpressure: none here; the caller qualifies the grant with its accept condition.
module adder_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  localparam logic [IW:0] NREQ_W = NREQ[IW:0];

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   pos;
  logic [IW:0]     sum;

  always_comb begin
    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
    rot = NREQ'({req, req} >> ptr);
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) pos = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, pos};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    idx = sum[IW-1:0];
    any = |req;
    gnt = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// One 4-bit adder shared by NREQ requesters through a round-robin grant; ADDER_ARB_CARRY_EN keeps the carry.
// Latency: 1 cycle from request handshake to rsp_valid.
// Backpressure: req_ready is all-zero while the response buffer is full and rsp_ready is low.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid,
  output logic [NREQ-1:0]                   req_ready,
  input  logic [NREQ*DW-1:0]                req_a,
  input  logic [NREQ*DW-1:0]                req_b,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DW+ARB_CARRY-1:0]           rsp_sum,
  output logic [$clog2(NREQ)-1:0]           rsp_id
);

  localparam int IW = $clog2((NREQ > ARB_NREQ_MAX) ? ARB_NREQ_MAX : NREQ);
  localparam int SW = DW + ARB_CARRY;

  buf_state_t      state;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   g_idx;
  logic            g_any;
  logic            can_accept;
  logic            take;
  nibble_t         a_sel;
  nibble_t         b_sel;
  logic [SW-1:0]   add_out;

  adder_arb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (g_idx),
    .any (g_any)
  );

  // Drain and refill may happen on the same edge, so a full buffer still accepts when rsp_ready.
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign take       = rst_n & can_accept & g_any;
  assign req_ready  = take ? gnt : '0;
  assign rsp_valid  = (state == FULL);

  assign a_sel   = req_a[g_idx*DW +: DW];
  assign b_sel   = req_b[g_idx*DW +: DW];
  assign add_out = SW'({1'b0, a_sel} + {1'b0, b_sel});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rsp_sum <= '0;
      rsp_id  <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (take) begin
            state   <= FULL;
            rsp_sum <= add_out;
            rsp_id  <= g_idx;
            rr_ptr  <= IW'(rr_next(int'(g_idx), NREQ));
          end
        end
        FULL: begin
          if (take) begin
            rsp_sum <= add_out;
            rsp_id  <= g_idx;
            rr_ptr  <= IW'(rr_next(int'(g_idx), NREQ));
          end else if (rsp_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
